// File: rtl/alu_4bit.sv
// alu_4bit: registered 4-bit ALU; in clk, rst, a_i, b_i, op_i; out result_o, carry_o, overflow_o, zero_o, negative_o
module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] op_i,
  output logic [3:0] result_o,
  output logic       carry_o,
  output logic       overflow_o,
  output logic       zero_o,
  output logic       negative_o
);
  logic [3:0] result_d, result_q;
  logic       carry_d, carry_q, overflow_d, overflow_q, zero_q, negative_q;
  logic [4:0] sum, diff;
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  always_comb begin
    result_d   = 4'h0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op_i)
      4'h0: begin
        result_d   = sum[3:0];
        carry_d    = sum[4];
        overflow_d = (a_i[3] == b_i[3]) && (sum[3] != a_i[3]);
      end
      4'h1: begin
        result_d   = diff[3:0];
        carry_d    = diff[4];
        overflow_d = (a_i[3] != b_i[3]) && (diff[3] != a_i[3]);
      end
      4'h2: result_d = a_i & b_i;
      4'h3: result_d = a_i | b_i;
      4'h4: result_d = a_i ^ b_i;
      4'h5: result_d = ~a_i;
      4'h6: {carry_d, result_d} = {a_i, 1'b0};
      4'h7: {result_d, carry_d} = {1'b0, a_i};
      4'h8: {result_d, carry_d} = {a_i[3], a_i};
      4'h9: {carry_d, result_d} = {a_i[3], a_i[2:0], a_i[3]};
      4'ha: {result_d, carry_d} = {a_i[0], a_i[3:1], a_i[0]};
      4'hb: begin
        result_d   = a_i + 4'd1;
        carry_d    = &a_i;
        overflow_d = a_i == 4'b0111;
      end
      4'hc: begin
        result_d   = a_i - 4'd1;
        carry_d    = ~|a_i;
        overflow_d = a_i == 4'b1000;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= 4'h0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= result_d == 4'h0;
      negative_q <= result_d[3];
    end
  end
  assign result_o   = result_q;
  assign carry_o    = carry_q;
  assign overflow_o = overflow_q;
  assign zero_o     = zero_q;
  assign negative_o = negative_q;
endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: self-checking bench for alu_4bit against an arithmetic reference model
module tb_alu_4bit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = 4'h0, b = 4'h0, op = 4'h0;
  logic [3:0] result;
  logic       carry, overflow, zero, negative;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_4bit dut (
    .clk(clk), .rst(rst), .a_i(a), .b_i(b), .op_i(op),
    .result_o(result), .carry_o(carry), .overflow_o(overflow),
    .zero_o(zero), .negative_o(negative)
  );

  // {result, carry, overflow, zero, negative}
  function automatic logic [7:0] model(input logic r, input int ua, input int ub, input int o);
    int sa, sb, s, res, c, v;
    sa = ua >= 8 ? ua - 16 : ua;
    sb = ub >= 8 ? ub - 16 : ub;
    res = 0; c = 0; v = 0;
    if (r) return 8'h00;
    case (o)
      0: begin s = ua + ub; res = s % 16; c = int'(s > 15); v = int'(sa + sb > 7 || sa + sb < -8); end
      1: begin res = (ua - ub + 16) % 16; c = int'(ua < ub); v = int'(sa - sb > 7 || sa - sb < -8); end
      2: res = ua & ub;
      3: res = ua | ub;
      4: res = ua ^ ub;
      5: res = 15 - ua;
      6: begin res = (ua * 2) % 16; c = ua / 8; end
      7: begin res = ua / 2; c = ua % 2; end
      8: begin res = ua / 2 + (ua >= 8 ? 8 : 0); c = ua % 2; end
      9: begin res = (ua * 2) % 16 + ua / 8; c = ua / 8; end
      10: begin res = ua / 2 + (ua % 2) * 8; c = ua % 2; end
      11: begin res = (ua + 1) % 16; c = int'(ua == 15); v = int'(sa + 1 > 7); end
      12: begin res = (ua + 15) % 16; c = int'(ua == 0); v = int'(sa - 1 < -8); end
      default: ;
    endcase
    return {res[3:0], c[0], v[0], res == 0, res >= 8};
  endfunction

  task automatic step(input logic r, input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] to);
    @(negedge clk);
    rst = r; a = ta; b = tb; op = to;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'b1010, 4'b0110, 4'h0);
      got = {result, carry, overflow, zero, negative};
      checks++;
      if (got !== 8'h00) begin errors++; $display("FAIL reset[%0d]: got %b want %b", i, got, 8'h00); end
    end
    step(1'b0, 4'b1010, 4'b0110, 4'h0);
    got = {result, carry, overflow, zero, negative};
    checks++;
    if (got !== 8'b0000_1010) begin errors++; $display("FAIL reset_release: got %b want %b", got, 8'b0000_1010); end
  endtask

  logic [19:0] dir_vec [18] = '{
    {4'b1010, 4'b0110, 4'h1, 8'b0100_0100},
    {4'b1010, 4'b0110, 4'hb, 8'b1011_0001},
    {4'b1010, 4'b0110, 4'hc, 8'b1001_0001},
    {4'b1111, 4'b0000, 4'hb, 8'b0000_1010},
    {4'b0111, 4'b0000, 4'hb, 8'b1000_0101},
    {4'b0000, 4'b0000, 4'hc, 8'b1111_1001},
    {4'b1000, 4'b0011, 4'hc, 8'b0111_0100},
    {4'b1010, 4'b0110, 4'h2, 8'b0010_0000},
    {4'b1010, 4'b0110, 4'h3, 8'b1110_0001},
    {4'b1010, 4'b0110, 4'h4, 8'b1100_0001},
    {4'b1010, 4'b0110, 4'h5, 8'b0101_0000},
    {4'b1010, 4'b0110, 4'h6, 8'b0100_1000},
    {4'b1010, 4'b0110, 4'h7, 8'b0101_0000},
    {4'b1010, 4'b0110, 4'h8, 8'b1101_0001},
    {4'b1010, 4'b0110, 4'h9, 8'b0101_1000},
    {4'b1010, 4'b0110, 4'ha, 8'b0101_0000},
    {4'b0101, 4'b0100, 4'h0, 8'b1001_0101},
    {4'b1011, 4'b0110, 4'hd, 8'b0000_0010}
  };

  task automatic test_directed();
    logic [7:0] got;
    for (int i = 0; i < 18; i++) begin
      step(1'b0, dir_vec[i][19:16], dir_vec[i][15:12], dir_vec[i][11:8]);
      got = {result, carry, overflow, zero, negative};
      checks++;
      if (got !== dir_vec[i][7:0]) begin
        errors++;
        $display("FAIL directed[%0d] op=%h a=%b b=%b: got %b want %b", i, dir_vec[i][11:8], dir_vec[i][19:16], dir_vec[i][15:12], got, dir_vec[i][7:0]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] got, exp;
    logic [3:0] ta, tb;
    int o;
    o = 0;
    while (o < 16) begin
      ta = 4'($urandom_range(15)); tb = 4'($urandom_range(15));
      if (o == 7 && !rst) begin
        step(1'b1, ta, tb, 4'(o));
        exp = 8'h00;
      end else begin
        step(1'b0, ta, tb, 4'(o));
        exp = model(1'b0, int'(ta), int'(tb), o);
        o++;
      end
      got = {result, carry, overflow, zero, negative};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL sweep op=%0d rst=%b: got %b want %b", o, rst, got, exp); end
      if (o >= 14 && got[7:4] !== 4'h0 && !rst) begin
        errors++; $display("FAIL sweep_reserved op=%0d: got %b want 0000", o - 1, got[7:4]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    logic [3:0] ta, tb, to;
    logic tr;
    for (int i = 0; i < 400; i++) begin
      ta = 4'($urandom_range(15)); tb = 4'($urandom_range(15)); to = 4'($urandom_range(15));
      tr = $urandom_range(19) == 0;
      step(tr, ta, tb, to);
      exp = model(tr, int'(ta), int'(tb), int'(to));
      got = {result, carry, overflow, zero, negative};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d] rst=%b op=%h a=%b b=%b: got %b want %b", i, tr, to, ta, tb, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_4bit.md
# alu_4bit

Registered 4-bit arithmetic/logic unit with status flags. Each clock edge it samples two operands and a 4-bit opcode and registers the result with carry, overflow, zero and negative flags. It serves as the datapath execute stage for small 4-bit cores and sits between operand selection and result write-back.

## Interface
- No parameters; width is fixed at 4 bits.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  4  operand A (unsigned, or two's complement for signed flags).
- b  input  4  operand B.
- op  input  4  opcode, see Operation.
- result  output  4  registered result.
- carry  output  1  registered carry / borrow / shifted-out bit.
- overflow  output  1  registered signed-overflow flag.
- zero  output  1  registered; 1 when result is 0000.
- negative  output  1  registered; equals result[3].

## Operation
- 0000 ADD: result = a+b mod 16.
  - carry = bit 4 of the sum.
  - overflow = (a[3]==b[3]) && (result[3]!=a[3]).
- 0001 SUB: result = a-b mod 16.
  - carry = borrow, i.e. 1 when a<b unsigned.
  - overflow = (a[3]!=b[3]) && (result[3]!=a[3]).
- 0010 AND, 0011 OR, 0100 XOR: bitwise a with b.
- 0101 NOT: result = ~a.
- Logic ops 0010-0101: carry=0, overflow=0.
- 0110 SHL: result = {a[2:0],0}, carry = a[3].
- 0111 SHR (logical): result = {0,a[3:1]}, carry = a[0].
- 1000 ASR: result = {a[3],a[3:1]}, carry = a[0].
- 1001 ROL: result = {a[2:0],a[3]}, carry = a[3].
- 1010 ROR: result = {a[0],a[3:1]}, carry = a[0].
- Shifts and rotates 0110-1010: overflow=0.
- 1011 INC: result = a+1.
  - carry = 1 only when a=1111.
  - overflow = 1 only when a=0111.
- 1100 DEC: result = a-1.
  - carry (borrow) = 1 only when a=0000.
  - overflow = 1 only when a=1000.
- 1101-1111 (reserved): result=0000, carry=0, overflow=0, zero=1, negative=0.
- b is ignored for 0101-1100.
- zero and negative are derived from the result being registered, for every opcode.

## Timing
- Fully synchronous, one-cycle latency.
  - a, b and op are sampled at rising edge N.
  - All five outputs reflect that operation after edge N and hold until edge N+1.
- No handshake. A new operation is accepted every cycle, and outputs change only on clock edges.
- Reset: when rst=1 at a rising edge, result=0000 and carry=overflow=zero=negative=0. Reset overrides the op presented in that cycle.
- Zero reads 0 during reset even though result is 0000. The zero flag is only meaningful after the first non-reset edge.
- Releasing rst mid-stream: the first edge with rst=0 registers the op then present. No pipeline history remains.
- Before the first reset, output values are unspecified.

## Test plan
- Reset: hold rst=1 for 2 edges with a=1010, b=0110, op=0000 -> all outputs 0. Release rst -> next edge gives result=0000, carry=1, overflow=0, zero=1, negative=0.
- Arithmetic, a=1010, b=0110:
  - SUB -> 0100, carry 0, overflow 1.
  - INC -> 1011, flags 0 except negative=1.
  - DEC -> 1001, negative 1.
  - Edges: INC of 1111 -> 0000 with carry 1, zero 1. INC of 0111 -> overflow 1. DEC of 0000 -> 1111 with carry 1.
- Logic, a=1010, b=0110:
  - AND -> 0010.
  - OR -> 1110, negative 1.
  - XOR -> 1100, negative 1.
  - NOT -> 0101.
  - Carry and overflow are 0 for all four.
- Shifts, a=1010:
  - SHL -> 0100, carry 1.
  - SHR -> 0101, carry 0.
  - ASR -> 1101, negative 1.
  - ROL -> 0101, carry 1.
  - ROR -> 0101, carry 0.
- Sweep op 0000-1111, one opcode per cycle back-to-back.
  - Each result appears exactly one edge after its op.
  - Reserved opcodes 1101-1111 -> 0000 with zero 1.
  - Assert rst mid-sweep -> outputs clear on that edge, and the sweep resumes correctly after release.
